// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate lanes: lane state encoding and barrier timeout.
package parking_pkg;

    localparam int unsigned OPEN_TIMEOUT = 20;
    localparam int unsigned TIMER_W      = 5;
    localparam logic [TIMER_W-1:0] OPEN_TIMEOUT_CNT = TIMER_W'(OPEN_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StOpen,
        StCommit,
        StWaitRelease
    } lane_state_e;

endpackage

// File: rtl/parking_lane_fsm.sv
// One gate lane: latches the vehicle class, optionally checks vacancy, runs the barrier
// with a pass timeout and flags a single commit per vehicle.
module parking_lane_fsm
    import parking_pkg::*;
#(
    parameter bit CheckVacancy = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_request,
    input  logic i_is_uni,
    input  logic i_passed,
    input  logic i_uni_space,
    input  logic i_gen_space,
    output logic o_barrier_open,
    output logic o_commit,
    output logic o_is_uni,
    output logic o_denied
);

    lane_state_e        r_state, w_state_next;
    logic [TIMER_W-1:0] r_timer, w_timer_next, w_timer_inc;
    logic               r_is_uni, w_is_uni_next;
    logic               r_denied, w_deny;
    logic               w_has_space;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_timer  <= '0;
            r_is_uni <= 1'b0;
            r_denied <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_timer  <= w_timer_next;
            r_is_uni <= w_is_uni_next;
            r_denied <= w_deny;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_timer_next  = r_timer;
        w_is_uni_next = r_is_uni;
        w_deny        = 1'b0;
        w_timer_inc   = r_timer + TIMER_W'(1);
        w_has_space   = !CheckVacancy || (r_is_uni ? i_uni_space : i_gen_space);

        unique case (r_state)
            StIdle: begin
                w_timer_next = '0;
                if (i_request) begin
                    w_is_uni_next = i_is_uni;
                    w_state_next  = StCheck;
                end
            end
            StCheck: begin
                w_timer_next = '0;
                if (w_has_space) begin
                    w_state_next = StOpen;
                end else begin
                    w_deny       = 1'b1;
                    w_state_next = StWaitRelease;
                end
            end
            StOpen: begin
                // Vacancy is deliberately ignored here: once raised, the entry is honoured.
                if (i_passed) begin
                    w_state_next = StCommit;
                end else if (w_timer_inc == OPEN_TIMEOUT_CNT) begin
                    w_state_next = StWaitRelease;
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end
            StCommit: begin
                w_state_next = StWaitRelease;
            end
            StWaitRelease: begin
                if (!i_request) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_barrier_open = (r_state == StOpen);
    assign o_commit       = (r_state == StCommit);
    assign o_is_uni       = r_is_uni;
    assign o_denied       = r_denied;

endmodule

// File: rtl/parking_gate_controller.sv
// Parking gate controller: entry and exit lanes plus the event arbiter that serialises
// simultaneous commits toward the space manager (exit first, entry one cycle later).
module parking_gate_controller
    import parking_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic entry_request,
    input  logic entry_is_uni,
    input  logic exit_request,
    input  logic exit_is_uni,
    input  logic entry_passed,
    input  logic exit_passed,
    input  logic uni_is_vacated_space,
    input  logic is_vacated_space,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic car_exited,
    output logic is_uni_car_exited,
    output logic entry_barrier_open,
    output logic exit_barrier_open,
    output logic entry_denied
);

    logic w_entry_commit, w_entry_is_uni;
    logic w_exit_commit, w_exit_is_uni;
    logic w_unused_exit_denied;
    logic w_entry_solo, w_collide;
    logic w_car_entered_next, w_is_uni_entered_next;

    logic r_car_entered, r_is_uni_entered;
    logic r_car_exited, r_is_uni_exited;
    logic r_defer_valid, r_defer_is_uni;

    parking_lane_fsm #(
        .CheckVacancy (1'b1)
    ) u_entry_lane (
        .clk            (clk),
        .rst            (rst),
        .i_request      (entry_request),
        .i_is_uni       (entry_is_uni),
        .i_passed       (entry_passed),
        .i_uni_space    (uni_is_vacated_space),
        .i_gen_space    (is_vacated_space),
        .o_barrier_open (entry_barrier_open),
        .o_commit       (w_entry_commit),
        .o_is_uni       (w_entry_is_uni),
        .o_denied       (entry_denied)
    );

    parking_lane_fsm #(
        .CheckVacancy (1'b0)
    ) u_exit_lane (
        .clk            (clk),
        .rst            (rst),
        .i_request      (exit_request),
        .i_is_uni       (exit_is_uni),
        .i_passed       (exit_passed),
        .i_uni_space    (1'b1),
        .i_gen_space    (1'b1),
        .o_barrier_open (exit_barrier_open),
        .o_commit       (w_exit_commit),
        .o_is_uni       (w_exit_is_uni),
        .o_denied       (w_unused_exit_denied)
    );

    // A deferred entry never meets a fresh commit: both lanes sit in WAIT_RELEASE after COMMIT.
    always_comb begin
        w_entry_solo          = w_entry_commit & ~w_exit_commit;
        w_collide             = w_entry_commit & w_exit_commit;
        w_car_entered_next    = r_defer_valid | w_entry_solo;
        w_is_uni_entered_next = r_defer_valid ? r_defer_is_uni : (w_entry_solo & w_entry_is_uni);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_car_entered    <= 1'b0;
            r_is_uni_entered <= 1'b0;
            r_car_exited     <= 1'b0;
            r_is_uni_exited  <= 1'b0;
            r_defer_valid    <= 1'b0;
            r_defer_is_uni   <= 1'b0;
        end else begin
            r_car_entered    <= w_car_entered_next;
            r_is_uni_entered <= w_is_uni_entered_next;
            r_car_exited     <= w_exit_commit;
            r_is_uni_exited  <= w_exit_commit & w_exit_is_uni;
            r_defer_valid    <= w_collide;
            r_defer_is_uni   <= w_collide & w_entry_is_uni;
        end
    end

    assign car_entered        = r_car_entered;
    assign is_uni_car_entered = r_is_uni_entered;
    assign car_exited         = r_car_exited;
    assign is_uni_car_exited  = r_is_uni_exited;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Randomised bench for parking_gate_controller; each vehicle's outcome is predicted from
// class, vacancy and pass delay, then compared with what the gate outputs actually did.
module tb_parking_gate_controller;

    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic entry_request = 1'b0, entry_is_uni = 1'b0;
    logic exit_request = 1'b0, exit_is_uni = 1'b0;
    logic entry_passed = 1'b0, exit_passed = 1'b0;
    logic uni_is_vacated_space = 1'b0, is_vacated_space = 1'b0;
    logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic entry_barrier_open, exit_barrier_open, entry_denied;
    logic [6:0] outs;

    int n_checks = 0;
    int n_failures = 0;
    int uni_parked = 0;

    parking_gate_controller u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .entry_request        (entry_request),
        .entry_is_uni         (entry_is_uni),
        .exit_request         (exit_request),
        .exit_is_uni          (exit_is_uni),
        .entry_passed         (entry_passed),
        .exit_passed          (exit_passed),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited),
        .entry_barrier_open   (entry_barrier_open),
        .exit_barrier_open    (exit_barrier_open),
        .entry_denied         (entry_denied)
    );

    assign outs = {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
                   entry_barrier_open, exit_barrier_open, entry_denied};

    always #5 clk = ~clk;

    // Space manager model: counts university cars admitted.
    always @(negedge clk) begin
        if (car_entered && is_uni_car_entered) uni_parked <= uni_parked + 1;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One vehicle on one lane (0 = entry, 1 = exit); delay >= TIMEOUT means it never passes.
    task automatic run_lane(input bit lane, input bit cls, input bit uni_sp, input bit gen_sp,
                            input int delay);
        int bc = 0, ev = 0, ev_uni = 0, stray = 0, den = 0, other = 0;
        int set_at = -1, ev_at = -1;
        bit granted;
        int exp_ev, exp_bc;
        granted = lane ? 1'b1 : (cls ? uni_sp : gen_sp);
        exp_ev  = (granted && delay < TIMEOUT) ? 1 : 0;
        exp_bc  = !granted ? 0 : ((delay < TIMEOUT) ? delay + 1 : TIMEOUT);
        @(negedge clk);
        uni_is_vacated_space = uni_sp;
        is_vacated_space     = gen_sp;
        if (lane) begin
            exit_request = 1'b1;
            exit_is_uni  = cls;
        end else begin
            entry_request = 1'b1;
            entry_is_uni  = cls;
        end
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            entry_passed = 1'b0;
            exit_passed  = 1'b0;
            if (lane ? exit_barrier_open : entry_barrier_open) begin
                bc++;
                // Class and vacancy wander once open; neither may affect this vehicle.
                uni_is_vacated_space = 1'($urandom_range(0, 1));
                is_vacated_space     = 1'($urandom_range(0, 1));
                if (lane) exit_is_uni = 1'($urandom_range(0, 1));
                else entry_is_uni = 1'($urandom_range(0, 1));
                if (bc == delay + 1) begin
                    if (lane) exit_passed = 1'b1;
                    else entry_passed = 1'b1;
                    set_at = c;
                end
            end
            if (lane ? car_exited : car_entered) begin
                ev++;
                ev_at = c;
                if (lane ? is_uni_car_exited : is_uni_car_entered) ev_uni++;
            end
            if ((!car_entered && is_uni_car_entered) || (!car_exited && is_uni_car_exited)) stray++;
            if (entry_denied) den++;
            if (lane ? (entry_barrier_open || car_entered) : (exit_barrier_open || car_exited))
                other++;
        end
        entry_request = 1'b0;
        exit_request  = 1'b0;
        entry_passed  = 1'b0;
        exit_passed   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq($sformatf("L%0d barrier_cycles", lane), bc, exp_bc);
        check_eq($sformatf("L%0d events", lane), ev, exp_ev);
        check_eq($sformatf("L%0d event_class", lane), ev_uni, (exp_ev == 1 && cls) ? 1 : 0);
        check_eq($sformatf("L%0d denied", lane), den, (!lane && !granted) ? 1 : 0);
        check_eq($sformatf("L%0d stray_class", lane), stray, 0);
        check_eq($sformatf("L%0d other_lane_quiet", lane), other, 0);
        if (exp_ev == 1 && ev == 1)
            check_eq($sformatf("L%0d event_latency", lane), ev_at - set_at, 2);
    endtask

    // Both lanes pass on the same cycle; optionally reset while the entry event is deferred.
    task automatic both_lanes(input bit cls_en, input bit cls_ex, input int delay,
                              input bit rst_on_exit);
        int bc_en = 0, en_n = 0, ex_n = 0, en_at = -1, ex_at = -1, set_at = -1;
        int en_uni = 0, ex_uni = 0;
        @(negedge clk);
        uni_is_vacated_space = 1'b1;
        is_vacated_space     = 1'b1;
        entry_request = 1'b1;
        entry_is_uni  = cls_en;
        exit_request  = 1'b1;
        exit_is_uni   = cls_ex;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            entry_passed = 1'b0;
            exit_passed  = 1'b0;
            rst          = 1'b0;
            if (entry_barrier_open) bc_en++;
            if (entry_barrier_open && exit_barrier_open && bc_en == delay + 1) begin
                entry_passed = 1'b1;
                exit_passed  = 1'b1;
                set_at = c;
            end
            if (car_entered) begin
                en_n++;
                en_at  = c;
                en_uni = int'(is_uni_car_entered);
            end
            if (car_exited) begin
                ex_n++;
                ex_at  = c;
                ex_uni = int'(is_uni_car_exited);
                if (rst_on_exit) begin
                    rst           = 1'b1;
                    entry_request = 1'b0;
                    exit_request  = 1'b0;
                end
            end
        end
        entry_request = 1'b0;
        exit_request  = 1'b0;
        rst           = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("both exit_count", ex_n, 1);
        check_eq("both exit_latency", ex_at - set_at, 2);
        check_eq("both exit_class", ex_uni, int'(cls_ex));
        if (rst_on_exit) begin
            check_eq("both deferred_dropped_by_reset", en_n, 0);
        end else begin
            check_eq("both entry_count", en_n, 1);
            check_eq("both entry_after_exit", en_at - ex_at, 1);
            check_eq("both entry_class", en_uni, int'(cls_en));
        end
    endtask

    task automatic reset_mid_open(input int k);
        int bc = 0, guard = 0, late = 0;
        @(negedge clk);
        uni_is_vacated_space = 1'b1;
        entry_request = 1'b1;
        entry_is_uni  = 1'b1;
        while (bc < k && guard < 40) begin
            @(negedge clk);
            guard++;
            if (entry_barrier_open) bc++;
        end
        check_eq("rst_reach_open", bc, k);
        rst           = 1'b1;
        entry_passed  = 1'b1;
        entry_request = 1'b0;
        @(negedge clk);
        check_eq("rst_outputs_low", int'(outs), 0);
        rst          = 1'b0;
        entry_passed = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (car_entered || entry_barrier_open) late++;
        end
        check_eq("rst_no_late_event", late, 0);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", int'(outs), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_lane(1'b0, 1'b1, 1'b1, 1'b0, 3);   // uni entry, passes after 3 open cycles
        run_lane(1'b0, 1'b0, 1'b1, 1'b0, 5);   // general entry, no general space
        run_lane(1'b1, 1'b0, 1'b0, 1'b0, 25);  // exit never passes: timeout
        run_lane(1'b1, 1'b1, 1'b0, 1'b0, 2);   // exit re-armed after request fell
        run_lane(1'b0, 1'b0, 1'b0, 1'b1, 19);  // pass on the last open cycle
        both_lanes(1'b1, 1'b0, 4, 1'b0);
        both_lanes(1'b0, 1'b1, int'($urandom_range(0, 19)), 1'b0);
        both_lanes(1'b1, 1'b1, int'($urandom_range(0, 10)), 1'b1);
        reset_mid_open(int'($urandom_range(1, 10)));

        for (int i = 0; i < 24; i++) begin
            run_lane(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 24)));
        end

        base = uni_parked;
        for (int i = 0; i < 10; i++) begin
            run_lane(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        end
        check_eq("uni_parked_delta", uni_parked - base, 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
